// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_pkg
//  Description : Shared types and constants for the instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_pkg;

    localparam int unsigned c_inst_w   = 32;
    localparam logic [31:0] c_reset_pc = 32'h1C00_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch
//  Description : Single-outstanding instruction fetch with one-entry output
//                buffer and branch redirect / stale-response drop.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                fStall,
    input  logic                br_taken,
    input  logic [31:0]         br_target,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [c_inst_w-1:0] imem_rdata,
    output logic                imem_rready,
    output logic                IF_valid,
    output logic [31:0]         IF_pc,
    output logic [c_inst_w-1:0] IF_inst
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;

    always_comb begin
        imem_req    = (r_state == FETCH);
        imem_addr   = r_pc;
        imem_rready = 1'b0;
        case (r_state)
            // A redirect always takes the response so it can be retired unseen.
            WAIT:    imem_rready = br_taken || !IF_valid || !fStall;
            DROP:    imem_rready = 1'b1;
            default: imem_rready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            IF_valid <= 1'b0;
            IF_pc    <= 32'd0;
            IF_inst  <= '0;
        end else begin
            if (IF_valid && !fStall) begin
                IF_valid <= 1'b0;
            end

            case (r_state)
                FETCH: begin
                    if (imem_ready) begin
                        r_state <= br_taken ? DROP : WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid && imem_rready) begin
                        r_state <= FETCH;
                        if (!br_taken) begin
                            IF_valid <= 1'b1;
                            IF_pc    <= r_pc;
                            IF_inst  <= imem_rdata;
                            r_pc     <= r_pc + 32'd4;
                        end
                    end else if (br_taken) begin
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        r_state <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase

            // Redirect overrides both the stall and any same-cycle load.
            if (br_taken) begin
                r_pc     <= align_word(br_target);
                IF_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch
//  Description : Self-checking bench for if_fetch against a transaction model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    localparam logic [31:0] c_tb_reset_pc = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fStall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_rready;
    logic        IF_valid;
    logic [31:0] IF_pc;
    logic [31:0] IF_inst;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(c_tb_reset_pc)) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .fStall      (fStall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_rready (imem_rready),
        .IF_valid    (IF_valid),
        .IF_pc       (IF_pc),
        .IF_inst     (IF_inst)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory model and expected-stream model
    bit          m_out      = 1'b0;
    bit          m_stale    = 1'b0;
    logic [31:0] m_resp_addr = 32'd0;
    int          m_lat      = 0;
    int          rdy_pct    = 100;
    int          lat_lo     = 0;
    int          lat_hi     = 0;
    bit          exp_ifv    = 1'b0;
    logic [31:0] exp_pc     = 32'd0;
    logic [31:0] exp_inst   = 32'd0;
    logic [31:0] exp_next   = c_tb_reset_pc;
    bit          last_accept = 1'b0;
    int          n_loads    = 0;

    task automatic cycle(input bit a_rstn, input bit a_stall, input bit a_br, input logic [31:0] a_tgt);
        bit          s_req, s_ready, s_rvalid, s_rready, taken, accept;
        logic [31:0] s_addr;
        bit          exp_rr;
        rstn        = a_rstn;
        fStall      = a_stall;
        br_taken    = a_br;
        br_target   = a_tgt;
        imem_ready  = (int'($urandom_range(0, 99)) < rdy_pct);
        imem_rvalid = m_out && (m_lat == 0);
        imem_rdata  = m_out ? mem_word(m_resp_addr) : 32'hDEAD_BEEF;
        #1;
        s_req    = imem_req;
        s_addr   = imem_addr;
        s_ready  = imem_ready;
        s_rvalid = imem_rvalid;
        s_rready = imem_rready;
        if (a_rstn) begin
            check_eq("imem_req", 32'(s_req), 32'(!m_out));
            if (!m_out)                exp_rr = 1'b0;
            else if (m_stale || a_br)  exp_rr = 1'b1;
            else                       exp_rr = !exp_ifv || !a_stall;
            check_eq("imem_rready", 32'(s_rready), 32'(exp_rr));
        end
        @(posedge clk);
        taken       = a_rstn && s_rvalid && s_rready;
        accept      = a_rstn && s_req && s_ready;
        last_accept = accept;
        if (!a_rstn) begin
            m_out    = 1'b0;
            m_stale  = 1'b0;
            exp_ifv  = 1'b0;
            exp_pc   = 32'd0;
            exp_inst = 32'd0;
            exp_next = c_tb_reset_pc;
        end else begin
            if (exp_ifv && !a_stall) exp_ifv = 1'b0;
            if (taken) begin
                if (!m_stale && !a_br) begin
                    exp_ifv  = 1'b1;
                    exp_pc   = m_resp_addr;
                    exp_inst = mem_word(m_resp_addr);
                    exp_next = m_resp_addr + 32'd4;
                    n_loads++;
                end
                m_out   = 1'b0;
                m_stale = 1'b0;
            end else if (m_out && m_lat > 0) begin
                m_lat--;
            end
            if (a_br) begin
                exp_ifv  = 1'b0;
                exp_next = a_tgt & 32'hFFFF_FFFC;
                if (m_out) m_stale = 1'b1;
            end
            if (accept) begin
                if (!a_br) check_eq("fetch_addr", s_addr, exp_next);
                m_out       = 1'b1;
                m_stale     = a_br;
                m_resp_addr = s_addr;
                m_lat       = int'($urandom_range(lat_lo, lat_hi));
            end
        end
        #1;
        check_eq("IF_valid", 32'(IF_valid), 32'(exp_ifv));
        if (exp_ifv || !a_rstn) begin
            check_eq("IF_pc", IF_pc, exp_pc);
            check_eq("IF_inst", IF_inst, exp_inst);
        end
    endtask

    task automatic wait_accept();
        int guard = 0;
        cycle(1, 0, 0, 32'd0);
        while (!last_accept && guard < 20) begin
            cycle(1, 0, 0, 32'd0);
            guard++;
        end
        check_eq("wait_accept", 32'(last_accept), 32'd1);
    endtask

    task automatic wait_valid();
        int guard = 0;
        while (!IF_valid && guard < 20) begin
            cycle(1, 0, 0, 32'd0);
            guard++;
        end
        check_eq("wait_valid", 32'(IF_valid), 32'd1);
    endtask

    initial begin
        int base;
        rstn = 1'b0; fStall = 1'b0; br_taken = 1'b0; br_target = 32'd0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;

        repeat (3) cycle(0, 0, 0, 32'd0);

        // Zero-wait streaming: one instruction every two cycles
        base = n_loads;
        repeat (20) cycle(1, 0, 0, 32'd0);
        check_eq("throughput", 32'(n_loads - base), 32'd10);

        // Stall with a buffered instruction and a response waiting
        wait_valid();
        repeat (3) cycle(1, 1, 0, 32'd0);
        repeat (6) cycle(1, 0, 0, 32'd0);

        // Redirect one cycle after accept, slow memory: stale response dropped
        lat_lo = 2; lat_hi = 2;
        wait_accept();
        cycle(1, 0, 1, 32'h1C00_0103);
        repeat (12) cycle(1, 0, 0, 32'd0);

        // Redirect coincident with response in WAIT
        lat_lo = 0; lat_hi = 0;
        wait_accept();
        cycle(1, 0, 1, 32'h1C00_0200);
        repeat (6) cycle(1, 0, 0, 32'd0);

        // Stall and redirect together
        wait_valid();
        cycle(1, 1, 1, 32'h1C00_0300);
        repeat (6) cycle(1, 0, 0, 32'd0);

        // PC wrap, then reset while a request is outstanding
        cycle(1, 0, 1, 32'hFFFF_FFFC);
        repeat (8) cycle(1, 0, 0, 32'd0);
        lat_lo = 3; lat_hi = 3;
        wait_accept();
        cycle(1, 0, 0, 32'd0);
        repeat (2) cycle(0, 0, 0, 32'd0);
        lat_lo = 0; lat_hi = 0;
        repeat (6) cycle(1, 0, 0, 32'd0);

        // Randomized traffic
        rdy_pct = 70; lat_lo = 0; lat_hi = 3;
        repeat (3000) begin
            cycle($urandom_range(0, 199) != 0,
                  $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 5,
                  $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
